// File: rtl/led_pixel_read_queue.sv
// led_pixel_read_queue
//
// Bridges the LED matrix controller's pixel-fetch port to a pipelined
// Avalon-MM read master on the frame-buffer memory. Row-fetch addresses are
// buffered in a circular queue and issued with a bounded number of reads in
// flight. Read data comes back in order as single-cycle strobes. A flush
// discards queued and in-flight reads when the frame buffer is switched.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_address/valid   request push from the controller
//   req_full            back-pressure (one slot of headroom kept)
//   flush               one-cycle pulse, drops queued and in-flight reads
//   rsp_data/valid      returned pixel word, one-cycle strobe, registered
//   overflow            sticky, set when a request is dropped
//   mem_*               Avalon-MM pipelined read master
//   stall_cycles        only with LED_PIXEL_READ_QUEUE_STATS_EN defined:
//                       saturating count of cycles with read stalled
//
// Optional feature macro: LED_PIXEL_READ_QUEUE_STATS_EN

module led_pixel_read_queue #(
    parameter int ADDRESS_WIDTH = 25,
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 16,
    parameter int MAX_PENDING   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic                     req_valid,
    output logic                     req_full,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_valid,
    output logic                     overflow,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read,
    input  logic                     mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]    mem_readdata,
    input  logic                     mem_readdatavalid
`ifdef LED_PIXEL_READ_QUEUE_STATS_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] MAX_PEND = 8'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, ISSUE, THROTTLE, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [7:0]               pending_q, pending_d;
    logic                     mem_read_q, mem_read_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     overflow_q, overflow_d;

    logic [ADDRESS_WIDTH-1:0] queue_q [DEPTH];

    logic                     push;
    logic                     pop;
    logic                     accept;
    logic                     rsp_ok;
    logic [ADDRESS_WIDTH-1:0] head_next;

    always_comb begin
        push   = req_valid && (count_q < CNT_W'(DEPTH)) && (state_q != FLUSH);
        accept = mem_read_q && !mem_waitrequest;
        // The read held through a flush no longer owns a queue slot.
        pop    = accept && (state_q != FLUSH);
        // Stray data with nothing outstanding is ignored entirely.
        rsp_ok = mem_readdatavalid && (pending_q != 8'd0);

        // With a single entry left, the next head is the one being written
        // this very cycle, so bypass the storage.
        head_next = (count_q > CNT_W'(1)) ? queue_q[rd_ptr_q + PTR_W'(1)] : req_address;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        pending_d = pending_q;
        case ({accept, rsp_ok})
            2'b10:   pending_d = pending_q + 8'd1;
            2'b01:   pending_d = pending_q - 8'd1;
            default: pending_d = pending_q;
        endcase

        overflow_d  = overflow_q
                    | (req_valid && ((count_q == CNT_W'(DEPTH)) || (state_q == FLUSH)));

        rsp_valid_d = rsp_ok && (state_q != FLUSH) && !flush;
        rsp_data_d  = rsp_ok ? mem_readdata : rsp_data_q;

        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;

        case (state_q)
            IDLE: begin
                mem_read_d = 1'b0;
                if (count_q != '0) begin
                    if (pending_q < MAX_PEND) begin
                        state_d       = ISSUE;
                        mem_read_d    = 1'b1;
                        mem_address_d = queue_q[rd_ptr_q];
                    end else begin
                        state_d = THROTTLE;
                    end
                end
            end
            ISSUE: begin
                mem_read_d = 1'b1;
                if (accept) begin
                    if (count_d == '0) begin
                        state_d    = IDLE;
                        mem_read_d = 1'b0;
                    end else if (pending_q + 8'd1 == MAX_PEND) begin
                        state_d    = THROTTLE;
                        mem_read_d = 1'b0;
                    end else begin
                        mem_address_d = head_next;
                    end
                end
            end
            THROTTLE: begin
                mem_read_d = 1'b0;
                if (count_q == '0) begin
                    state_d = IDLE;
                end else if (pending_q < MAX_PEND) begin
                    state_d       = ISSUE;
                    mem_read_d    = 1'b1;
                    mem_address_d = queue_q[rd_ptr_q];
                end
            end
            FLUSH: begin
                // An unaccepted read must stay up until the slave takes it.
                mem_read_d = mem_read_q && mem_waitrequest;
                if ((pending_q == 8'd0) && !mem_read_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush && (state_q != FLUSH)) begin
            state_d       = FLUSH;
            mem_read_d    = mem_read_q && mem_waitrequest;
            mem_address_d = mem_address_q;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pending_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            overflow_q    <= overflow_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wr_ptr_q] <= req_address;
        end
    end

`ifdef LED_PIXEL_READ_QUEUE_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (flush) begin
            stall_cycles_d = '0;
        end else if (mem_read_q && mem_waitrequest && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign req_full    = (count_q >= CNT_W'(DEPTH - 1)) || (state_q == FLUSH);
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_led_pixel_read_queue.sv
// tb_led_pixel_read_queue
//
// Directed bench for led_pixel_read_queue. A small Avalon slave model returns
// the low 16 address bits as data two cycles after each accepted read when
// auto_en is set; otherwise the bench drives read-data strobes by hand.

module tb_led_pixel_read_queue;

    logic        clk;
    logic        reset;
    logic [24:0] req_address;
    logic        req_valid;
    logic        req_full;
    logic        flush;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        overflow;
    logic [24:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [15:0] mem_readdata;
    logic        mem_readdatavalid;
`ifdef LED_PIXEL_READ_QUEUE_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic        auto_en;
    logic        man_rdv;
    logic [15:0] man_data;
    logic        p1_v, p2_v;
    logic [15:0] p1_d, p2_d;

    led_pixel_read_queue dut (
        .clk               (clk),
        .reset             (reset),
        .req_address       (req_address),
        .req_valid         (req_valid),
        .req_full          (req_full),
        .flush             (flush),
        .rsp_data          (rsp_data),
        .rsp_valid         (rsp_valid),
        .overflow          (overflow),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
`ifdef LED_PIXEL_READ_QUEUE_STATS_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage memory latency model, reset together with the DUT.
    always @(posedge clk) begin
        if (reset) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_d <= '0;
            p2_d <= '0;
        end else begin
            p1_v <= mem_read && !mem_waitrequest && auto_en;
            p1_d <= mem_address[15:0];
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end

    assign mem_readdatavalid = auto_en ? p2_v : man_rdv;
    assign mem_readdata      = auto_en ? p2_d : man_data;

    task automatic applyStimulus(input logic valid, input logic [24:0] addr,
                                 input logic wait_req, input logic flush_in);
        req_valid       = valid;
        req_address     = addr;
        mem_waitrequest = wait_req;
        flush           = flush_in;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset   = 1'b1;
        auto_en = 1'b0;
        man_rdv = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int reads;
        int first_rd;
        int last_rd;
        int nrsp;
        int seen;
        int not_full;
        logic [24:0] last_addr;
        logic [15:0] got [8];

        reset    = 1'b1;
        man_data = '0;
        doReset();

        $display("[TB] reset values");
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_req_full", 32'(req_full), 32'd0);

        $display("[TB] 8-request burst with 2-cycle memory latency");
        auto_en  = 1'b1;
        reads    = 0;
        first_rd = -1;
        last_rd  = -1;
        nrsp     = 0;
        for (int c = 0; c < 24; c++) begin
            applyStimulus(c < 8, 25'h100 + 25'(c), 1'b0, 1'b0);
            if (mem_read) begin
                reads++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (rsp_valid) begin
                if (nrsp < 8) got[nrsp] = rsp_data;
                nrsp++;
            end
        end
        checkOutput("burst_reads", 32'(reads), 32'd8);
        checkOutput("burst_consecutive", 32'(last_rd - first_rd), 32'd7);
        checkOutput("burst_rsp_count", 32'(nrsp), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("burst_rsp_data%0d", i), 32'(got[i]), 32'h100 + 32'(i));
        end
        checkOutput("burst_overflow", 32'(overflow), 32'd0);

        $display("[TB] pending limit and throttle");
        doReset();
        reads = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(c < 12, 25'h200 + 25'(c), 1'b0, 1'b0);
            if (mem_read) reads++;
        end
        checkOutput("thr_accepts", 32'(reads), 32'd8);
        checkOutput("thr_mem_read_low", 32'(mem_read), 32'd0);
        man_rdv  = 1'b1;
        man_data = 16'hBEEF;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        man_rdv = 1'b0;
        checkOutput("thr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("thr_rsp_data", 32'(rsp_data), 32'hBEEF);
        reads     = 0;
        last_addr = '0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            if (mem_read) begin
                reads++;
                last_addr = mem_address;
            end
        end
        checkOutput("thr_one_more_accept", 32'(reads), 32'd1);
        checkOutput("thr_next_address", 32'(last_addr), 32'h208);

        $display("[TB] queue fill with waitrequest held");
        doReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 25'h100 + 25'(i), 1'b1, 1'b0);
        end
        checkOutput("fill14_req_full", 32'(req_full), 32'd0);
        applyStimulus(1'b1, 25'h10E, 1'b1, 1'b0);
        checkOutput("fill15_req_full", 32'(req_full), 32'd1);
        checkOutput("fill15_mem_read", 32'(mem_read), 32'd1);
        checkOutput("fill15_mem_address", 32'(mem_address), 32'h100);
        checkOutput("fill15_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 25'h10F, 1'b1, 1'b0);
        checkOutput("fill16_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 25'h110, 1'b1, 1'b0);
        checkOutput("fill17_overflow", 32'(overflow), 32'd1);
        checkOutput("fill17_mem_address", 32'(mem_address), 32'h100);

        $display("[TB] flush with a stalled read and 3 pending");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 25'h300 + 25'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("fl_pre_mem_read", 32'(mem_read), 32'd1);
        checkOutput("fl_pre_mem_address", 32'(mem_address), 32'h303);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("fl_req_full", 32'(req_full), 32'd1);
        checkOutput("fl_read_held", 32'(mem_read), 32'd1);
        checkOutput("fl_address_held", 32'(mem_address), 32'h303);
        applyStimulus(1'b1, 25'h3FF, 1'b1, 1'b0);
        checkOutput("fl_drop_overflow", 32'(overflow), 32'd1);
        checkOutput("fl_read_still_held", 32'(mem_read), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("fl_read_released", 32'(mem_read), 32'd0);
        checkOutput("fl_req_full_after_accept", 32'(req_full), 32'd1);
        seen     = 0;
        not_full = 0;
        man_data = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            man_rdv = 1'b1;
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            if (rsp_valid) seen++;
            if (!req_full) not_full++;
        end
        man_rdv = 1'b0;
        checkOutput("fl_no_rsp_valid", 32'(seen), 32'd0);
        checkOutput("fl_full_throughout", 32'(not_full), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("fl_idle_req_full", 32'(req_full), 32'd0);
        checkOutput("fl_idle_mem_read", 32'(mem_read), 32'd0);
        applyStimulus(1'b1, 25'h3AA, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("fl_new_mem_read", 32'(mem_read), 32'd1);
        checkOutput("fl_new_address", 32'(mem_address), 32'h3AA);

        $display("[TB] reset mid-burst");
        doReset();
        auto_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 25'h500 + 25'(i), 1'b0, 1'b0);
        end
        checkOutput("mid_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("mid_rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("mid_rst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
        checkOutput("mid_rst_req_full", 32'(req_full), 32'd0);
        reads = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            if (mem_read) reads++;
        end
        checkOutput("mid_rst_queue_empty", 32'(reads), 32'd0);

`ifdef LED_PIXEL_READ_QUEUE_STATS_EN
        $display("[TB] stall statistics");
        doReset();
        applyStimulus(1'b1, 25'h700, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stats_start", stall_cycles, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("stats_five", stall_cycles, 32'd5);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("stats_flush_clear", stall_cycles, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
